// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the multi-cycle control unit:
// FSM states, opcodes, control-field encodings and the decode bundle.
package multicycle_control_unit_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_MULDIV = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_CMP   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LUI   = 2'b11;

  localparam logic [2:0] WB_ALU = 3'b000;
  localparam logic [2:0] WB_MEM = 3'b001;
  localparam logic [2:0] WB_PC4 = 3'b010;
  localparam logic [2:0] WB_CSR = 3'b011;
  localparam logic [2:0] WB_MD  = 3'b100;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;
  localparam logic [1:0] PC_TRAP  = 2'b11;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b010;
  localparam logic [2:0] BR_GE  = 3'b011;
  localparam logic [2:0] BR_LTU = 3'b100;
  localparam logic [2:0] BR_GEU = 3'b101;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;

  // trap_cause != 0 marks a trapping instruction
  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
    logic [2:0] branch_type;
    logic [2:0] wb_sel;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic       dmem_we;
    logic       csr_read_en;
    logic       csr_write_en;
    logic [3:0] trap_cause;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_md;
    logic       is_jal;
    logic       is_jalr;
    logic       rd_zero;
  } dec_t;

  function automatic logic [2:0] br_map(input logic [2:0] f3);
    logic [2:0] r;
    r = BR_EQ;
    case (f3)
      3'b001:  r = BR_NE;
      3'b100:  r = BR_LT;
      3'b101:  r = BR_GE;
      3'b110:  r = BR_LTU;
      3'b111:  r = BR_GEU;
      default: r = BR_EQ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Handshake bundle between the control unit (master) and the
// imem / dmem / mul-div side (slave).
interface multicycle_control_unit_if;
  logic        imem_req;
  logic        imem_ready;
  logic        ir_load;
  logic [31:0] instr;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        md_start;
  logic        md_done;

  modport master (
    output imem_req, ir_load, dmem_req, dmem_we,
    output mem_size, mem_unsigned, md_start,
    input  imem_ready, instr, dmem_ready, md_done
  );

  modport slave (
    input  imem_req, ir_load, dmem_req, dmem_we,
    input  mem_size, mem_unsigned, md_start,
    output imem_ready, instr, dmem_ready, md_done
  );
endinterface

// File: rtl/multicycle_control_unit_instr_decoder.sv
// Combinational RV32I/M classifier with illegal/ECALL/EBREAK detection.
// Ports: instr in; dec (dec_t bundle) out.
module multicycle_control_unit_instr_decoder
  import multicycle_control_unit_pkg::*;
#(
  parameter bit ENABLE_M   = 1'b1,
  parameter bit ENABLE_CSR = 1'b1
) (
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [11:0] imm;
  logic        ill;
  logic        ecall;
  logic        ebreak;
  dec_t        d;

  assign opc = instr[6:0];
  assign rd  = instr[11:7];
  assign f3  = instr[14:12];
  assign rs1 = instr[19:15];
  assign f7  = instr[31:25];
  assign imm = instr[31:20];

  always_comb begin
    d      = '0;
    ill    = 1'b0;
    ecall  = 1'b0;
    ebreak = 1'b0;
    unique case (opc)
      OP_REG: begin
        d.alu_op = ALU_FUNCT;
        d.wb_sel = WB_ALU;
        if (f7 == 7'b0000001) begin
          if (ENABLE_M) begin
            d.is_md  = 1'b1;
            d.wb_sel = WB_MD;
          end else begin
            ill = 1'b1;
          end
        end else if (!(f7 == 7'b0 ||
                       (f7 == 7'b0100000 &&
                        (f3 == 3'b000 || f3 == 3'b101)))) begin
          ill = 1'b1;
        end
      end
      OP_IMM: begin
        d.alu_src = 1'b1;
        d.alu_op  = ALU_FUNCT;
        if (f3 == 3'b001 && f7 != 7'b0) ill = 1'b1;
        if (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000)
          ill = 1'b1;
      end
      OP_LUI: begin
        d.alu_src = 1'b1;
        d.alu_op  = ALU_LUI;
      end
      OP_AUIPC: begin
        d.alu_src = 1'b1;
        d.alu_op  = ALU_ADD;
      end
      OP_JAL: begin
        d.wb_sel = WB_PC4;
        d.is_jal = 1'b1;
      end
      OP_JALR: begin
        d.alu_src = 1'b1;
        d.wb_sel  = WB_PC4;
        d.is_jalr = 1'b1;
      end
      OP_BRANCH: begin
        d.alu_op      = ALU_CMP;
        d.is_branch   = 1'b1;
        d.branch_type = br_map(f3);
        if (f3[2:1] == 2'b01) ill = 1'b1;
      end
      OP_LOAD: begin
        d.alu_src      = 1'b1;
        d.wb_sel       = WB_MEM;
        d.is_load      = 1'b1;
        d.mem_size     = f3[1:0];
        d.mem_unsigned = f3[2];
        if (f3 == 3'b011 || f3[2:1] == 2'b11) ill = 1'b1;
      end
      OP_STORE: begin
        d.alu_src  = 1'b1;
        d.dmem_we  = 1'b1;
        d.is_store = 1'b1;
        d.mem_size = f3[1:0];
        if (f3 > 3'b010) ill = 1'b1;
      end
      OP_SYSTEM: begin
        if (f3 == 3'b000) begin
          if (imm == 12'd0)      ecall  = 1'b1;
          else if (imm == 12'd1) ebreak = 1'b1;
          else                   ill    = 1'b1;
        end else if (f3 == 3'b100 || !ENABLE_CSR) begin
          ill = 1'b1;
        end else begin
          // CSRRW(I) to x0 skips the read; CSRRS/C(I) with x0/0 skip the write
          d.wb_sel       = WB_CSR;
          d.csr_read_en  = !(f3[1:0] == 2'b01 && rd == 5'd0);
          d.csr_write_en = !(f3[1] && rs1 == 5'd0);
        end
      end
      default: ill = 1'b1;
    endcase
    d.rd_zero = (rd == 5'd0);
    if (ill || ecall || ebreak) begin
      d = '0;
      d.trap_cause = ill    ? CAUSE_ILLEGAL :
                     ebreak ? CAUSE_EBREAK  : CAUSE_ECALL;
    end
  end

  assign dec = d;

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32IM control FSM: fetch/decode/exec/mem/muldiv/wb/trap.
// Ports: clk, rst, bus (handshakes), branch_taken; control outputs.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter bit ENABLE_M   = 1'b1,
  parameter bit ENABLE_CSR = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  multicycle_control_unit_if.master  bus,
  input  logic                       branch_taken,
  output logic                       alu_src,
  output logic [1:0]                 alu_op,
  output logic [2:0]                 branch_type,
  output logic                       reg_write,
  output logic [2:0]                 wb_sel,
  output logic                       pc_write,
  output logic [1:0]                 pc_src,
  output logic                       csr_read_en,
  output logic                       csr_write_en,
  output logic                       trap,
  output logic [3:0]                 trap_cause,
  output logic                       retire,
  output logic [2:0]                 state
);

  state_t state_q, state_d;
  dec_t   dec, dec_q;
  logic   imem_req, ir_load, dmem_req, md_start;

  multicycle_control_unit_instr_decoder #(
    .ENABLE_M   (ENABLE_M),
    .ENABLE_CSR (ENABLE_CSR)
  ) u_dec (
    .instr (bus.instr),
    .dec   (dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) dec_q <= dec;
    end
  end

  // rst gates every strobe so they drop the instant reset asserts
  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    dmem_req  = 1'b0;
    md_start  = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    trap      = 1'b0;
    retire    = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (bus.imem_ready) begin
            ir_load = 1'b1;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          state_d = (dec.trap_cause != 4'd0) ? ST_TRAP : ST_EXEC;
        end
        ST_EXEC: begin
          unique case (1'b1)
            dec_q.is_load, dec_q.is_store: state_d = ST_MEM;
            dec_q.is_md: begin
              md_start = 1'b1;
              state_d  = ST_MULDIV;
            end
            dec_q.is_branch: begin
              pc_write = 1'b1;
              pc_src   = branch_taken ? PC_IMM : PC_PLUS4;
              retire   = 1'b1;
              state_d  = ST_FETCH;
            end
            default: state_d = ST_WB;
          endcase
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          if (bus.dmem_ready) begin
            if (dec_q.is_store) begin
              pc_write = 1'b1;
              retire   = 1'b1;
              state_d  = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end
        end
        ST_MULDIV: begin
          if (bus.md_done) state_d = ST_WB;
        end
        ST_WB: begin
          reg_write = !dec_q.rd_zero;
          pc_write  = 1'b1;
          retire    = 1'b1;
          pc_src    = dec_q.is_jal  ? PC_IMM  :
                      dec_q.is_jalr ? PC_JALR : PC_PLUS4;
          state_d   = ST_FETCH;
        end
        ST_TRAP: begin
          trap     = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_TRAP;
          state_d  = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  assign bus.imem_req     = imem_req;
  assign bus.ir_load      = ir_load;
  assign bus.dmem_req     = dmem_req;
  assign bus.md_start     = md_start;
  assign bus.dmem_we      = dec_q.dmem_we;
  assign bus.mem_size     = dec_q.mem_size;
  assign bus.mem_unsigned = dec_q.mem_unsigned;

  assign alu_src      = dec_q.alu_src;
  assign alu_op       = dec_q.alu_op;
  assign branch_type  = dec_q.branch_type;
  assign wb_sel       = dec_q.wb_sel;
  assign csr_read_en  = dec_q.csr_read_en;
  assign csr_write_en = dec_q.csr_write_en;
  assign trap_cause   = dec_q.trap_cause;
  assign state        = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: vector table + scoreboard,
// plus hand sequences for disabled M/CSR and reset during MEM.
module tb_multicycle_control_unit;

  typedef struct {
    logic [31:0] ins;
    int bt, dw, mw;
    int cyc, ret, trp, cause, pcs, rw, wb;
    int asrc, aop, bty, sz, uns, we, crd, cwr;
    int dreq, mds;
  } vec_t;

  logic clk, rst;
  logic imem_ready, dmem_ready, md_done, branch_taken;
  logic [31:0] instr;

  logic       alu_src, reg_write, pc_write, trap, retire;
  logic       csr_read_en, csr_write_en;
  logic [1:0] alu_op, pc_src;
  logic [2:0] branch_type, wb_sel, state;
  logic [3:0] trap_cause;

  logic       alu_src2, reg_write2, pc_write2, trap2, retire2;
  logic       csr_read_en2, csr_write_en2;
  logic [1:0] alu_op2, pc_src2;
  logic [2:0] branch_type2, wb_sel2, state2;
  logic [3:0] trap_cause2;

  multicycle_control_unit_if bus1();
  multicycle_control_unit_if bus2();

  assign bus1.imem_ready = imem_ready;
  assign bus1.instr      = instr;
  assign bus1.dmem_ready = dmem_ready;
  assign bus1.md_done    = md_done;
  assign bus2.imem_ready = imem_ready;
  assign bus2.instr      = instr;
  assign bus2.dmem_ready = dmem_ready;
  assign bus2.md_done    = md_done;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .bus(bus1),
    .branch_taken(branch_taken),
    .alu_src(alu_src), .alu_op(alu_op),
    .branch_type(branch_type), .reg_write(reg_write),
    .wb_sel(wb_sel), .pc_write(pc_write), .pc_src(pc_src),
    .csr_read_en(csr_read_en), .csr_write_en(csr_write_en),
    .trap(trap), .trap_cause(trap_cause),
    .retire(retire), .state(state)
  );

  multicycle_control_unit #(
    .ENABLE_M(1'b0), .ENABLE_CSR(1'b0)
  ) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .branch_taken(branch_taken),
    .alu_src(alu_src2), .alu_op(alu_op2),
    .branch_type(branch_type2), .reg_write(reg_write2),
    .wb_sel(wb_sel2), .pc_write(pc_write2), .pc_src(pc_src2),
    .csr_read_en(csr_read_en2), .csr_write_en(csr_write_en2),
    .trap(trap2), .trap_cause(trap_cause2),
    .retire(retire2), .state(state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   vidx   = -1;
  int   trace[16];
  vec_t tab[$];
  vec_t sb[$];

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got 0x%0h want 0x%0h",
               n, vidx, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    md_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one instruction; memory/muldiv responders sit in the loop.
  task automatic run(input vec_t v);
    vec_t e;
    int cyc = 0, dcnt = 0, mcnt = 0, mds = 0, dreq = 0;
    bit mseen = 0, done = 0;
    sb.push_back(v);
    instr = v.ins;
    branch_taken = v.bt[0];
    for (int k = 0; k < 16; k++) trace[k] = -1;
    while (!done && cyc < 60) begin
      @(negedge clk);
      imem_ready = 1'b1;
      dmem_ready = (dcnt == v.dw);
      md_done = mseen && (mcnt == v.mw);
      #1;
      if (cyc < 16) trace[cyc] = int'(state);
      cyc++;
      if (bus1.dmem_req) begin
        dcnt++;
        dreq++;
      end
      if (bus1.md_start) begin
        mds++;
        mseen = 1;
        mcnt = 0;
      end
      if (mseen) mcnt++;
      if (retire || trap) begin
        done = 1;
        e = sb.pop_front();
        chk("cycles", cyc, e.cyc);
        chk("retire", int'(retire), e.ret);
        chk("trap", int'(trap), e.trp);
        chk("trap_cause", int'(trap_cause), e.cause);
        chk("pc_write", int'(pc_write), 1);
        chk("pc_src", int'(pc_src), e.pcs);
        chk("reg_write", int'(reg_write), e.rw);
        chk("wb_sel", int'(wb_sel), e.wb);
        chk("alu_src", int'(alu_src), e.asrc);
        chk("alu_op", int'(alu_op), e.aop);
        chk("branch_type", int'(branch_type), e.bty);
        chk("mem_size", int'(bus1.mem_size), e.sz);
        chk("mem_unsigned", int'(bus1.mem_unsigned), e.uns);
        chk("dmem_we", int'(bus1.dmem_we), e.we);
        chk("csr_read_en", int'(csr_read_en), e.crd);
        chk("csr_write_en", int'(csr_write_en), e.cwr);
        chk("dmem_req_cycles", dreq, e.dreq);
        chk("md_start_pulses", mds, e.mds);
      end
    end
    if (!done) begin
      void'(sb.pop_front());
      chk("timeout", cyc, -1);
    end
  endtask

  int rcnt;

  initial begin
    // ins bt dw mw | cyc ret trp cause pcs rw wb |
    // asrc aop bty sz uns we crd cwr | dreq mds
    tab.push_back('{32'h002081B3,0,0,0, 4,1,0,0, 0,1,0, 0,2,0,0,0,0,0,0, 0,0});
    tab.push_back('{32'h00500093,0,0,0, 4,1,0,0, 0,1,0, 1,2,0,0,0,0,0,0, 0,0});
    tab.push_back('{32'h00208033,0,0,0, 4,1,0,0, 0,0,0, 0,2,0,0,0,0,0,0, 0,0});
    tab.push_back('{32'h123452B7,0,0,0, 4,1,0,0, 0,1,0, 1,3,0,0,0,0,0,0, 0,0});
    tab.push_back('{32'h008000EF,0,0,0, 4,1,0,0, 1,1,2, 0,0,0,0,0,0,0,0, 0,0});
    tab.push_back('{32'h000100E7,0,0,0, 4,1,0,0, 2,1,2, 1,0,0,0,0,0,0,0, 0,0});
    tab.push_back('{32'h0000A283,0,3,0, 8,1,0,0, 0,1,1, 1,0,0,2,0,0,0,0, 4,0});
    tab.push_back('{32'h0000C283,0,0,0, 5,1,0,0, 0,1,1, 1,0,0,0,1,0,0,0, 1,0});
    tab.push_back('{32'h00209023,0,1,0, 5,1,0,0, 0,0,0, 1,0,0,1,0,1,0,0, 2,0});
    tab.push_back('{32'h0020E063,1,0,0, 3,1,0,0, 1,0,0, 0,1,4,0,0,0,0,0, 0,0});
    tab.push_back('{32'h0020E063,0,0,0, 3,1,0,0, 0,0,0, 0,1,4,0,0,0,0,0, 0,0});
    tab.push_back('{32'h0020D063,1,0,0, 3,1,0,0, 1,0,0, 0,1,3,0,0,0,0,0, 0,0});
    tab.push_back('{32'h00208063,0,0,0, 3,1,0,0, 0,0,0, 0,1,0,0,0,0,0,0, 0,0});
    tab.push_back('{32'h022081B3,0,0,5, 9,1,0,0, 0,1,4, 0,2,0,0,0,0,0,0, 0,1});
    tab.push_back('{32'h0220D1B3,0,0,1, 5,1,0,0, 0,1,4, 0,2,0,0,0,0,0,0, 0,1});
    tab.push_back('{32'h4020D1B3,0,0,0, 4,1,0,0, 0,1,0, 0,2,0,0,0,0,0,0, 0,0});
    tab.push_back('{32'h4010D093,0,0,0, 4,1,0,0, 0,1,0, 1,2,0,0,0,0,0,0, 0,0});
    tab.push_back('{32'h300110F3,0,0,0, 4,1,0,0, 0,1,3, 0,0,0,0,0,0,1,1, 0,0});
    tab.push_back('{32'h300020F3,0,0,0, 4,1,0,0, 0,1,3, 0,0,0,0,0,0,1,0, 0,0});
    tab.push_back('{32'h00000073,0,0,0, 3,0,1,11, 3,0,0, 0,0,0,0,0,0,0,0, 0,0});
    tab.push_back('{32'h00100073,0,0,0, 3,0,1,3, 3,0,0, 0,0,0,0,0,0,0,0, 0,0});
    tab.push_back('{32'h0000007F,0,0,0, 3,0,1,2, 3,0,0, 0,0,0,0,0,0,0,0, 0,0});
    tab.push_back('{32'h402091B3,0,0,0, 3,0,1,2, 3,0,0, 0,0,0,0,0,0,0,0, 0,0});
    tab.push_back('{32'h0200D093,0,0,0, 3,0,1,2, 3,0,0, 0,0,0,0,0,0,0,0, 0,0});
    tab.push_back('{32'h0020A063,0,0,0, 3,0,1,2, 3,0,0, 0,0,0,0,0,0,0,0, 0,0});
    tab.push_back('{32'h0000B283,0,0,0, 3,0,1,2, 3,0,0, 0,0,0,0,0,0,0,0, 0,0});
    tab.push_back('{32'h0020B023,0,0,0, 3,0,1,2, 3,0,0, 0,0,0,0,0,0,0,0, 0,0});
    tab.push_back('{32'h0000C073,0,0,0, 3,0,1,2, 3,0,0, 0,0,0,0,0,0,0,0, 0,0});
    tab.push_back('{32'h00200073,0,0,0, 3,0,1,2, 3,0,0, 0,0,0,0,0,0,0,0, 0,0});

    instr = 32'h0;
    branch_taken = 1'b0;
    rst = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    md_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_imem_req", int'(bus1.imem_req), 0);
    chk("rst_reg_write", int'(reg_write), 0);
    chk("rst_retire", int'(retire), 0);
    chk("rst_pc_write", int'(pc_write), 0);
    chk("rst_alu_op", int'(alu_op), 0);
    chk("rst_wb_sel", int'(wb_sel), 0);
    chk("rst_trap_cause", int'(trap_cause), 0);
    chk("rst_dmem_req", int'(bus1.dmem_req), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_imem_req", int'(bus1.imem_req), 1);
    chk("post_rst_state", int'(state), 0);

    for (int i = 0; i < tab.size(); i++) begin
      vidx = i;
      run(tab[i]);
      if (i == 0) begin
        chk("add_st0", trace[0], 0);
        chk("add_st1", trace[1], 1);
        chk("add_st2", trace[2], 2);
        chk("add_st3", trace[3], 5);
      end
    end

    vidx = 100;
    do_reset();
    instr = 32'h022081B3;
    imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("m_on_md_start", int'(bus1.md_start), 1);
    chk("m_on_state", int'(state), 2);
    chk("m_off_state", int'(state2), 6);
    chk("m_off_trap", int'(trap2), 1);
    chk("m_off_cause", int'(trap_cause2), 2);
    chk("m_off_pc_src", int'(pc_src2), 3);
    chk("m_off_retire", int'(retire2), 0);

    vidx = 101;
    do_reset();
    instr = 32'h300110F3;
    imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("csr_on_state", int'(state), 2);
    chk("csr_off_trap", int'(trap2), 1);
    chk("csr_off_cause", int'(trap_cause2), 2);

    vidx = 102;
    do_reset();
    instr = 32'h002081B3;
    imem_ready = 1'b1;
    md_done = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("md_done_ignored_state", int'(state), 5);
    chk("md_done_ignored_retire", int'(retire), 1);

    vidx = 103;
    do_reset();
    instr = 32'h0000A283;
    imem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_mem_state", int'(state), 3);
    chk("mid_mem_dmem_req", int'(bus1.dmem_req), 1);
    @(negedge clk);
    #1;
    chk("stall_dmem_req", int'(bus1.dmem_req), 1);
    chk("stall_mem_size", int'(bus1.mem_size), 2);
    rst = 1'b1;
    #1;
    chk("rst_mem_dmem_req", int'(bus1.dmem_req), 0);
    chk("rst_mem_state", int'(state), 0);
    chk("rst_mem_reg_write", int'(reg_write), 0);
    @(negedge clk);
    rst = 1'b0;
    imem_ready = 1'b0;
    #1;
    chk("rel_state", int'(state), 0);
    chk("rel_imem_req", int'(bus1.imem_req), 1);
    rcnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      if (retire) rcnt++;
    end
    chk("abandoned_retire", rcnt, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
